round_controller: RTL and testbench

- Match/round sequencer sitting directly downstream of the health tracker.
- Consumes both players' 4-bit health values and decides KO or time-up.
- Counts round wins and sequences intro/fight/KO/match-over phases on the frame tick.
- Drives fight_enable to the player FSMs and a round_reset pulse back to the health counters.

---
 rtl/round_controller.sv | 204 ++++++++++++++++++++
 tb/tb_round_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : round_controller
//  Description : Match/round sequencer. Watches both players' health, decides
//                KO or time-up, counts round wins and steps through the
//                intro / fight / KO / match-over phases on the frame tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module round_controller #(
    parameter int INTRO_FRAMES   = 120,
    parameter int KO_FRAMES      = 90,
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_TIME     = 60,
    parameter int ROUNDS_TO_WIN  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [3:0] player1_health,
    input  logic [3:0] player2_health,
    output logic       round_reset,
    output logic       fight_enable,
    output logic [2:0] game_state,
    output logic [6:0] round_timer,
    output logic [1:0] p1_wins,
    output logic [1:0] p2_wins,
    output logic [1:0] round_winner,
    output logic [1:0] match_winner
);

    // Phase encoding doubles as the game_state output value.
    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_INTRO      = 3'd1;
    localparam logic [2:0] c_FIGHT      = 3'd2;
    localparam logic [2:0] c_KO         = 3'd3;
    localparam logic [2:0] c_TIMEUP     = 3'd4;
    localparam logic [2:0] c_MATCH_OVER = 3'd5;

    localparam logic [1:0] c_WIN_NONE = 2'b00;
    localparam logic [1:0] c_WIN_P1   = 2'b01;
    localparam logic [1:0] c_WIN_P2   = 2'b10;
    localparam logic [1:0] c_WIN_DRAW = 2'b11;

    // One down-counter serves both the intro and the KO/time-up hold.
    localparam int c_FRAME_MAX = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
    localparam int c_FRAME_W   = $clog2(c_FRAME_MAX + 1);
    localparam int c_SUB_W     = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    localparam logic [c_FRAME_W-1:0] c_INTRO_LOAD = c_FRAME_W'(INTRO_FRAMES);
    localparam logic [c_FRAME_W-1:0] c_KO_LOAD    = c_FRAME_W'(KO_FRAMES);
    localparam logic [c_FRAME_W-1:0] c_FRAME_ONE  = c_FRAME_W'(1);
    localparam logic [c_SUB_W-1:0]   c_SUB_LAST   = c_SUB_W'(FRAMES_PER_SEC - 1);
    localparam logic [6:0]           c_TIME_LOAD  = 7'(ROUND_TIME);
    localparam logic [1:0]           c_WINS_GOAL  = 2'(ROUNDS_TO_WIN);

    logic [2:0]           r_state;
    logic [c_FRAME_W-1:0] r_frame_cnt;
    logic [c_SUB_W-1:0]   r_sub_cnt;
    logic                 r_round_reset;
    logic                 r_fight_enable;
    logic [6:0]           r_round_timer;
    logic [1:0]           r_p1_wins;
    logic [1:0]           r_p2_wins;
    logic [1:0]           r_round_winner;
    logic [1:0]           r_match_winner;

    logic                 w_p1_down;
    logic                 w_p2_down;
    logic                 w_any_down;
    logic                 w_sec_wrap;
    logic                 w_time_expire;
    logic                 w_phase_done;
    logic [1:0]           w_p1_wins_inc;
    logic [1:0]           w_p2_wins_inc;

    // Round-decision helpers evaluated from the current inputs and counters.
    always_comb begin
        w_p1_down     = (player1_health == 4'd0);
        w_p2_down     = (player2_health == 4'd0);
        w_any_down    = w_p1_down | w_p2_down;
        w_sec_wrap    = frame_tick && (r_sub_cnt == c_SUB_LAST);
        // A zero timer also counts as expiring so the timer can never wrap.
        w_time_expire = w_sec_wrap && (r_round_timer <= 7'd1);
        w_phase_done  = frame_tick && (r_frame_cnt <= c_FRAME_ONE);
        w_p1_wins_inc = (r_p1_wins == 2'd3) ? 2'd3 : r_p1_wins + 2'd1;
        w_p2_wins_inc = (r_p2_wins == 2'd3) ? 2'd3 : r_p2_wins + 2'd1;
    end

    // Phase sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_frame_cnt    <= '0;
            r_sub_cnt      <= '0;
            r_round_reset  <= 1'b0;
            r_fight_enable <= 1'b0;
            r_round_timer  <= 7'd0;
            r_p1_wins      <= 2'd0;
            r_p2_wins      <= 2'd0;
            r_round_winner <= c_WIN_NONE;
            r_match_winner <= c_WIN_NONE;
        end else begin
            r_round_reset <= 1'b0;
            case (r_state)
                c_IDLE, c_MATCH_OVER: begin
                    if (start) begin
                        r_round_reset  <= 1'b1;
                        r_p1_wins      <= 2'd0;
                        r_p2_wins      <= 2'd0;
                        r_round_winner <= c_WIN_NONE;
                        r_match_winner <= c_WIN_NONE;
                        r_round_timer  <= c_TIME_LOAD;
                        r_frame_cnt    <= c_INTRO_LOAD;
                        r_state        <= c_INTRO;
                    end
                end

                c_INTRO: begin
                    r_sub_cnt <= '0;
                    if (w_phase_done) begin
                        r_frame_cnt    <= '0;
                        r_fight_enable <= 1'b1;
                        r_state        <= c_FIGHT;
                    end else if (frame_tick) begin
                        r_frame_cnt <= r_frame_cnt - c_FRAME_ONE;
                    end
                end

                c_FIGHT: begin
                    if (w_any_down) begin
                        // KO wins over a coincident time-up; the timer freezes.
                        r_state        <= c_KO;
                        r_fight_enable <= 1'b0;
                        r_frame_cnt    <= c_KO_LOAD;
                        if (w_p1_down && w_p2_down) begin
                            r_round_winner <= c_WIN_DRAW;
                        end else if (w_p2_down) begin
                            r_round_winner <= c_WIN_P1;
                            r_p1_wins      <= w_p1_wins_inc;
                        end else begin
                            r_round_winner <= c_WIN_P2;
                            r_p2_wins      <= w_p2_wins_inc;
                        end
                    end else if (w_time_expire) begin
                        r_state        <= c_TIMEUP;
                        r_fight_enable <= 1'b0;
                        r_frame_cnt    <= c_KO_LOAD;
                        r_sub_cnt      <= '0;
                        r_round_timer  <= 7'd0;
                        if (player1_health > player2_health) begin
                            r_round_winner <= c_WIN_P1;
                            r_p1_wins      <= w_p1_wins_inc;
                        end else if (player2_health > player1_health) begin
                            r_round_winner <= c_WIN_P2;
                            r_p2_wins      <= w_p2_wins_inc;
                        end else begin
                            r_round_winner <= c_WIN_DRAW;
                        end
                    end else if (w_sec_wrap) begin
                        r_sub_cnt     <= '0;
                        r_round_timer <= r_round_timer - 7'd1;
                    end else if (frame_tick) begin
                        r_sub_cnt <= r_sub_cnt + c_SUB_W'(1);
                    end
                end

                c_KO, c_TIMEUP: begin
                    if (w_phase_done) begin
                        r_frame_cnt <= '0;
                        if ((r_p1_wins == c_WINS_GOAL) || (r_p2_wins == c_WINS_GOAL)) begin
                            r_state        <= c_MATCH_OVER;
                            r_match_winner <= (r_p1_wins == c_WINS_GOAL) ? c_WIN_P1 : c_WIN_P2;
                        end else begin
                            r_round_reset  <= 1'b1;
                            r_round_winner <= c_WIN_NONE;
                            r_round_timer  <= c_TIME_LOAD;
                            r_frame_cnt    <= c_INTRO_LOAD;
                            r_state        <= c_INTRO;
                        end
                    end else if (frame_tick) begin
                        r_frame_cnt <= r_frame_cnt - c_FRAME_ONE;
                    end
                end

                default: begin
                    r_state        <= c_IDLE;
                    r_fight_enable <= 1'b0;
                end
            endcase
        end
    end

    assign round_reset  = r_round_reset;
    assign fight_enable = r_fight_enable;
    assign game_state   = r_state;
    assign round_timer  = r_round_timer;
    assign p1_wins      = r_p1_wins;
    assign p2_wins      = r_p2_wins;
    assign round_winner = r_round_winner;
    assign match_winner = r_match_winner;

endmodule
`default_nettype wire

// File: tb/tb_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_round_controller
//  Description : Self-checking bench for round_controller. A reference model
//                tracks elapsed frame ticks per phase and derives the timer,
//                winners and phase changes arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_round_controller;

    localparam int c_INTRO = 3;
    localparam int c_KOF   = 2;
    localparam int c_FPS   = 2;
    localparam int c_RT    = 3;
    localparam int c_RTW   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [3:0] player1_health = 4'd3;
    logic [3:0] player2_health = 4'd3;
    logic       round_reset;
    logic       fight_enable;
    logic [2:0] game_state;
    logic [6:0] round_timer;
    logic [1:0] p1_wins;
    logic [1:0] p2_wins;
    logic [1:0] round_winner;
    logic [1:0] match_winner;

    round_controller #(
        .INTRO_FRAMES   (c_INTRO),
        .KO_FRAMES      (c_KOF),
        .FRAMES_PER_SEC (c_FPS),
        .ROUND_TIME     (c_RT),
        .ROUNDS_TO_WIN  (c_RTW)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .start          (start),
        .player1_health (player1_health),
        .player2_health (player2_health),
        .round_reset    (round_reset),
        .fight_enable   (fight_enable),
        .game_state     (game_state),
        .round_timer    (round_timer),
        .p1_wins        (p1_wins),
        .p2_wins        (p2_wins),
        .round_winner   (round_winner),
        .match_winner   (match_winner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: phase, ticks elapsed in that phase, and outputs.
    int m_phase = 0;
    int m_ticks = 0;
    int m_timer = 0;
    int m_p1w   = 0;
    int m_p2w   = 0;
    int m_rw    = 0;
    int m_mw    = 0;
    int m_rr    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 3) ? 3 : v + 1;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_update();
        int h1;
        int h2;
        h1 = int'(player1_health);
        h2 = int'(player2_health);
        m_rr = 0;
        if (reset) begin
            m_phase = 0; m_ticks = 0; m_timer = 0;
            m_p1w = 0; m_p2w = 0; m_rw = 0; m_mw = 0;
        end else begin
            case (m_phase)
                0, 5: if (start) begin
                    m_rr = 1; m_p1w = 0; m_p2w = 0; m_rw = 0; m_mw = 0;
                    m_timer = c_RT; m_phase = 1; m_ticks = 0;
                end
                1: if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == c_INTRO) begin m_phase = 2; m_ticks = 0; end
                end
                2: begin
                    if (h1 == 0 || h2 == 0) begin
                        m_phase = 3; m_ticks = 0;
                        if (h1 == 0 && h2 == 0) m_rw = 3;
                        else if (h2 == 0) begin m_rw = 1; m_p1w = sat_inc(m_p1w); end
                        else begin m_rw = 2; m_p2w = sat_inc(m_p2w); end
                    end else if (frame_tick) begin
                        m_ticks++;
                        m_timer = c_RT - m_ticks / c_FPS;
                        if (m_ticks == c_RT * c_FPS) begin
                            m_phase = 4; m_ticks = 0; m_timer = 0;
                            if (h1 > h2) begin m_rw = 1; m_p1w = sat_inc(m_p1w); end
                            else if (h2 > h1) begin m_rw = 2; m_p2w = sat_inc(m_p2w); end
                            else m_rw = 3;
                        end
                    end
                end
                3, 4: if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == c_KOF) begin
                        m_ticks = 0;
                        if (m_p1w == c_RTW || m_p2w == c_RTW) begin
                            m_phase = 5;
                            m_mw = (m_p1w == c_RTW) ? 1 : 2;
                        end else begin
                            m_rr = 1; m_rw = 0; m_timer = c_RT; m_phase = 1;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_all();
        check("game_state",   32'(game_state),   32'(m_phase));
        check("round_reset",  32'(round_reset),  32'(m_rr));
        check("fight_enable", 32'(fight_enable), 32'(m_phase == 2));
        check("round_timer",  32'(round_timer),  32'(m_timer));
        check("p1_wins",      32'(p1_wins),      32'(m_p1w));
        check("p2_wins",      32'(p2_wins),      32'(m_p2w));
        check("round_winner", 32'(round_winner), 32'(m_rw));
        check("match_winner", 32'(match_winner), 32'(m_mw));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later,
    // then the frame tick for the next edge is scheduled (every 4th clock).
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
        cyc++;
        frame_tick = ((cyc % 4) == 3);
    endtask

    task automatic wait_state(input int s, input string tag);
        for (int i = 0; i < 200 && int'(game_state) != s; i++) step();
        check(tag, 32'(game_state), 32'(s));
    endtask

    initial begin
        // Reset and idle
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_state", 32'(game_state), 32'd0);
        check("rst_timer", 32'(round_timer), 32'd0);

        // Start a match
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_rr", 32'(round_reset), 32'd1);
        check("start_state", 32'(game_state), 32'd1);
        check("start_timer", 32'(round_timer), 32'd3);
        // Health 0/15 and start during INTRO are ignored
        player1_health = 4'd0; player2_health = 4'd15; start = 1'b1;
        step();
        check("rr_one_cycle", 32'(round_reset), 32'd0);
        repeat (3) step();
        player1_health = 4'd3; player2_health = 4'd3; start = 1'b0;
        wait_state(2, "reach_fight");
        check("fight_en", 32'(fight_enable), 32'd1);

        // KO of player 2
        player2_health = 4'd0;
        step();
        player2_health = 4'd3;
        check("ko_state", 32'(game_state), 32'd3);
        check("ko_winner", 32'(round_winner), 32'd1);
        check("ko_p1w", 32'(p1_wins), 32'd1);
        wait_state(2, "round2_fight");

        // Reset in mid-fight with a win on the board
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_state", 32'(game_state), 32'd0);
        check("midrst_p1w", 32'(p1_wins), 32'd0);
        check("midrst_fe", 32'(fight_enable), 32'd0);

        // Randomized play against the model
        for (int n = 0; n < 6000; n++) begin
            reset = ($urandom_range(0, 799) == 0);
            start = ($urandom_range(0, 5) == 0);
            if (m_phase == 2) begin
                if (frame_tick && m_ticks == c_RT * c_FPS - 1 && $urandom_range(0, 2) == 0) begin
                    player1_health = 4'd0;
                    player2_health = 4'd0;
                end else begin
                    player1_health = ($urandom_range(0, 49) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
                    player2_health = ($urandom_range(0, 49) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
                end
            end else begin
                player1_health = 4'($urandom_range(0, 15));
                player2_health = 4'($urandom_range(0, 15));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
